// File: rtl/bru_pkg.sv
// Shared definitions for the branch-resolution unit: opcode codes, opcode
// width and redirect FSM state encoding.
package bru_pkg;

  localparam int unsigned BRU_CODE_BIT = 4;

  typedef enum logic [BRU_CODE_BIT-1:0] {
    BRU_NONE = 4'd0,
    BRU_EQZ  = 4'd1,
    BRU_NEZ  = 4'd2,
    BRU_JR   = 4'd3,
    BRU_EQ   = 4'd4,
    BRU_NE   = 4'd5,
    BRU_LT   = 4'd6,
    BRU_GE   = 4'd7,
    BRU_LTU  = 4'd8,
    BRU_GEU  = 4'd9,
    BRU_BL   = 4'd10,
    BRU_B    = 4'd11
  } bru_op_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } bru_state_e;

endpackage

// File: rtl/bru_resolve_if.sv
// Issue-side, redirect and perf signals of bru_resolve; slave is the unit,
// master is the surrounding pipeline / PC generator.
interface bru_resolve_if
  import bru_pkg::*;
#(
  parameter int unsigned GRLEN = 32
);

  logic                    in_valid;
  logic                    in_ready;
  logic [BRU_CODE_BIT-1:0] in_op;
  logic [GRLEN-1:0]        in_a;
  logic [GRLEN-1:0]        in_b;
  logic [GRLEN-1:0]        in_pc;
  logic [GRLEN-1:0]        in_offset;
  logic                    in_pred_taken;
  logic [GRLEN-1:0]        in_pred_target;
  logic                    ex_flush;
  logic                    out_valid;
  logic                    out_taken;
  logic [GRLEN-1:0]        out_target;
  logic [GRLEN-1:0]        out_link_pc;
  logic                    out_mispred;
  logic                    redirect_valid;
  logic [GRLEN-1:0]        redirect_target;
  logic                    redirect_ready;
  logic [31:0]             perf_br_cnt;
  logic [31:0]             perf_mis_cnt;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_pc, in_offset,
           in_pred_taken, in_pred_target, ex_flush, redirect_ready,
    output in_ready, out_valid, out_taken, out_target, out_link_pc,
           out_mispred, redirect_valid, redirect_target,
           perf_br_cnt, perf_mis_cnt
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_pc, in_offset,
           in_pred_taken, in_pred_target, ex_flush, redirect_ready,
    input  in_ready, out_valid, out_taken, out_target, out_link_pc,
           out_mispred, redirect_valid, redirect_target,
           perf_br_cnt, perf_mis_cnt
  );

endinterface

// File: rtl/bru_cond.sv
// Combinational branch condition and next-PC evaluator.
module bru_cond
  import bru_pkg::*;
#(
  parameter int unsigned GRLEN = 32
) (
  input  logic [BRU_CODE_BIT-1:0] op,
  input  logic [GRLEN-1:0]        a,
  input  logic [GRLEN-1:0]        b,
  input  logic [GRLEN-1:0]        pc,
  input  logic [GRLEN-1:0]        offset,
  output logic                    taken,
  output logic [GRLEN-1:0]        target,
  output logic [GRLEN-1:0]        link_pc
);

  logic [GRLEN-3:0] pc_word_next;
  logic [GRLEN-1:0] pc_rel;
  logic             eq;
  logic             lt_s;
  logic             lt_u;
  logic             a_zero;
  logic             unused_pc_lo;

  // Branch PCs are word aligned; the low PC bits never reach the result.
  assign unused_pc_lo = ^pc[1:0];
  assign pc_word_next = pc[GRLEN-1:2] + (GRLEN-2)'(1);
  assign pc_rel       = {pc[GRLEN-1:2], 2'b00} + offset;
  assign link_pc      = {pc_word_next, 2'b00};

  assign eq     = (a == b);
  assign lt_s   = ($signed(a) < $signed(b));
  assign lt_u   = (a < b);
  assign a_zero = (a == '0);

  always_comb begin
    taken = 1'b0;
    case (op)
      BRU_EQZ:             taken = a_zero;
      BRU_NEZ:             taken = !a_zero;
      BRU_JR, BRU_BL, BRU_B: taken = 1'b1;
      BRU_EQ:              taken = eq;
      BRU_NE:              taken = !eq;
      BRU_LT:              taken = lt_s;
      BRU_GE:              taken = !lt_s;
      BRU_LTU:             taken = lt_u;
      BRU_GEU:             taken = !lt_u;
      default:             taken = 1'b0;
    endcase
  end

  always_comb begin
    target = link_pc;
    if (taken) begin
      target = (op == BRU_JR) ? (a + offset) : pc_rel;
    end
  end

endmodule

// File: rtl/bru_resolve.sv
// Registered branch-resolution unit: condition evaluation, mispredict
// detection and a held redirect request. Optional perf counters: BRU_PERF_CNT_EN.
module bru_resolve
  import bru_pkg::*;
#(
  parameter int unsigned GRLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  bru_resolve_if.slave bus
);

  bru_state_e       state_q;
  bru_state_e       state_d;
  logic             accept;
  logic             c_taken;
  logic [GRLEN-1:0] c_target;
  logic [GRLEN-1:0] c_link;
  logic             c_mispred;
  logic             valid_q;
  logic             taken_q;
  logic [GRLEN-1:0] target_q;
  logic [GRLEN-1:0] link_q;
  logic             mispred_q;
  logic             in_ready_o;
  logic             redirect_valid_o;
  logic [GRLEN-1:0] redirect_target_o;

  bru_cond #(.GRLEN(GRLEN)) u_cond (
    .op      (bus.in_op),
    .a       (bus.in_a),
    .b       (bus.in_b),
    .pc      (bus.in_pc),
    .offset  (bus.in_offset),
    .taken   (c_taken),
    .target  (c_target),
    .link_pc (c_link)
  );

  assign accept = bus.in_valid && (state_q == IDLE) && !bus.ex_flush;

  // A not-taken prediction carries no meaningful target, so it is ignored.
  assign c_mispred = (bus.in_op != BRU_NONE) &&
                     ((c_taken != bus.in_pred_taken) ||
                      (c_taken && (c_target != bus.in_pred_target)));

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      target_q  <= '0;
      link_q    <= '0;
      mispred_q <= 1'b0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        taken_q   <= c_taken;
        target_q  <= c_target;
        link_q    <= c_link;
        mispred_q <= c_mispred;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.ex_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept && c_mispred) state_d = PEND;
        PEND:    if (bus.redirect_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // target_q cannot change while PEND because nothing is accepted there.
  always_comb begin
    in_ready_o        = (state_q == IDLE);
    redirect_valid_o  = (state_q == PEND);
    redirect_target_o = '0;
    if (state_q == PEND) begin
      redirect_target_o = target_q;
    end
  end

  assign bus.in_ready        = in_ready_o;
  assign bus.out_valid       = valid_q;
  assign bus.out_taken       = taken_q;
  assign bus.out_target      = target_q;
  assign bus.out_link_pc     = link_q;
  assign bus.out_mispred     = mispred_q;
  assign bus.redirect_valid  = redirect_valid_o;
  assign bus.redirect_target = redirect_target_o;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_cnt_q;
  logic [31:0] mis_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (accept && (bus.in_op != BRU_NONE)) br_cnt_q <= br_cnt_q + 32'd1;
      if (accept && c_mispred) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign bus.perf_br_cnt  = br_cnt_q;
  assign bus.perf_mis_cnt = mis_cnt_q;
`else
  assign bus.perf_br_cnt  = '0;
  assign bus.perf_mis_cnt = '0;
`endif

endmodule
